// File: rtl/ws2812_frame_ctrl_pkg.sv
// Shared types and defaults for the WS2812 capture path: shift-register control
// struct, frame controller states and the saturating counter helper.
package ws2812_frame_ctrl_pkg;

  localparam int unsigned CTRESET_CYCLES_DEFAULT = 2500;
  localparam int unsigned CPIXEL_BITS            = 24;

  typedef struct packed {
    logic shift_en;
    logic decode_bit;
    logic treset;
  } shift_reg_input_t;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    FORWARD = 2'd1,
    LATCH   = 2'd2
  } frame_ctrl_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel handoff from the frame controller to the PWM stage (valid/ready).
interface ws2812_frame_ctrl_if;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (output pixel_data, output pixel_valid, input  pixel_ready);
  modport slave  (input  pixel_data, input  pixel_valid, output pixel_ready);
endinterface

// File: rtl/ws2812_frame_ctrl_treset_timer.sv
// Line idle timer: counts consecutive low clocks and fires a single registered
// treset pulse per idle period once TRESET_CYCLES low clocks have been seen.
module ws2812_treset_timer
  import ws2812_frame_ctrl_pkg::*;
#(
  parameter int unsigned TRESET_CYCLES = CTRESET_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_din_level,
  output logic o_treset_pulse
);

  localparam int unsigned CW = $clog2(TRESET_CYCLES + 1);
  localparam logic [CW-1:0] CMAX  = CW'(TRESET_CYCLES);
  localparam logic [CW-1:0] CLAST = CW'(TRESET_CYCLES - 1);

  logic [CW-1:0] count_d, count_q;
  logic          pulse_d, pulse_q;

  // Saturation at CMAX keeps the pulse from re-firing during a long idle.
  always_comb begin
    count_d = count_q;
    pulse_d = 1'b0;
    if (i_din_level) begin
      count_d = '0;
    end else begin
      if (count_q != CMAX) begin
        count_d = count_q + CW'(1);
      end else begin
        count_d = count_q;
      end
      pulse_d = (count_q == CLAST);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_treset_pulse = pulse_q;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame controller: gates the capture shift register, detects treset,
// latches each pixel for the PWM stage. Optional stats: WS2812_FRAME_STATS_EN.
module ws2812_frame_ctrl
  import ws2812_frame_ctrl_pkg::*;
#(
  parameter int unsigned TRESET_CYCLES = CTRESET_CYCLES_DEFAULT,
  parameter int unsigned PIXEL_BITS    = CPIXEL_BITS
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_din_level,
  input  logic                       i_bit_valid,
  input  logic                       i_bit_value,
  input  logic [23:0]                i_led_data,
  output shift_reg_input_t           o_shift_reg,
  output logic                       o_frame_err,
  output logic                       o_overrun,
  output logic [15:0]                o_frame_count,
  output logic [15:0]                o_fwd_bits,
  ws2812_frame_ctrl_if.master        pix
);

  localparam logic [4:0] CPIX = 5'(PIXEL_BITS);

  frame_ctrl_state_t state_d, state_q;
  logic [4:0]        bit_cnt_d, bit_cnt_q;
  logic [23:0]       pixel_data_d, pixel_data_q;
  logic              pixel_valid_d, pixel_valid_q;
  logic              frame_err_d, frame_err_q;
  logic              overrun_d, overrun_q;
  logic              treset_s;
  logic              accept_s;

  ws2812_treset_timer #(.TRESET_CYCLES(TRESET_CYCLES)) u_treset_timer (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_din_level    (i_din_level),
    .o_treset_pulse (treset_s)
  );

  assign accept_s = pixel_valid_q && pix.pixel_ready;

  // Frame sequencing and pixel handshake next-state.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = accept_s ? 1'b0 : pixel_valid_q;
    frame_err_d   = 1'b0;
    overrun_d     = 1'b0;
    case (state_q)
      CAPTURE: begin
        if (treset_s) begin
          frame_err_d = (bit_cnt_q != 5'd0);
          bit_cnt_d   = 5'd0;
        end else if (i_bit_valid) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_d == CPIX) begin
            state_d = FORWARD;
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      FORWARD: begin
        if (treset_s) begin
          state_d = LATCH;
        end else begin
          state_d = FORWARD;
        end
      end
      LATCH: begin
        // A load coinciding with an accept replaces the pixel without loss.
        pixel_data_d  = i_led_data;
        pixel_valid_d = 1'b1;
        overrun_d     = pixel_valid_q && !accept_s;
        bit_cnt_d     = {4'd0, i_bit_valid};
        state_d       = CAPTURE;
      end
      default: begin
        state_d   = CAPTURE;
        bit_cnt_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= CAPTURE;
      bit_cnt_q     <= 5'd0;
      pixel_data_q  <= 24'd0;
      pixel_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
    end
  end

  // Only this LED's bits (and a bit arriving during LATCH) enter the shift register.
  always_comb begin
    o_shift_reg            = '0;
    o_shift_reg.treset     = treset_s;
    o_shift_reg.decode_bit = i_bit_value;
    if (state_q == CAPTURE || state_q == LATCH) begin
      o_shift_reg.shift_en = i_bit_valid;
    end else begin
      o_shift_reg.shift_en = 1'b0;
    end
  end

  assign pix.pixel_data  = pixel_data_q;
  assign pix.pixel_valid = pixel_valid_q;
  assign o_frame_err     = frame_err_q;
  assign o_overrun       = overrun_q;

`ifdef WS2812_FRAME_STATS_EN
  logic [15:0] fwd_cnt_d, fwd_cnt_q;
  logic [15:0] frame_count_d, frame_count_q;
  logic [15:0] fwd_bits_d, fwd_bits_q;

  // Per-frame forwarded-bit count and frame counter.
  always_comb begin
    fwd_cnt_d     = fwd_cnt_q;
    frame_count_d = frame_count_q;
    fwd_bits_d    = fwd_bits_q;
    if (state_q == LATCH) begin
      fwd_cnt_d     = 16'd0;
      frame_count_d = frame_count_q + 16'd1;
      fwd_bits_d    = fwd_cnt_q;
    end else if (state_q == FORWARD && i_bit_valid) begin
      fwd_cnt_d = sat_inc16(fwd_cnt_q);
    end else begin
      fwd_cnt_d = fwd_cnt_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fwd_cnt_q     <= 16'd0;
      frame_count_q <= 16'd0;
      fwd_bits_q    <= 16'd0;
    end else begin
      fwd_cnt_q     <= fwd_cnt_d;
      frame_count_q <= frame_count_d;
      fwd_bits_q    <= fwd_bits_d;
    end
  end

  assign o_frame_count = frame_count_q;
  assign o_fwd_bits    = fwd_bits_q;
`else
  assign o_frame_count = 16'd0;
  assign o_fwd_bits    = 16'd0;
`endif

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl with TRESET_CYCLES=8: table of frames
// plus hand sequences for latency, idle glitches, back-pressure and reset.
module tb_ws2812_frame_ctrl;
  import ws2812_frame_ctrl_pkg::*;

`ifdef WS2812_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             din   = 1'b1;
  logic             bv    = 1'b0;
  logic             bval  = 1'b0;
  logic [23:0]      sr_model;
  shift_reg_input_t sr_out;
  logic             err, ovr;
  logic [15:0]      fcnt, fbits;

  ws2812_frame_ctrl_if pix_if();

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(.TRESET_CYCLES(8), .PIXEL_BITS(24)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_din_level   (din),
    .i_bit_valid   (bv),
    .i_bit_value   (bval),
    .i_led_data    (sr_model),
    .o_shift_reg   (sr_out),
    .o_frame_err   (err),
    .o_overrun     (ovr),
    .o_frame_count (fcnt),
    .o_fwd_bits    (fbits),
    .pix           (pix_if)
  );

  // Downstream capture shift register, MSB first.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_model <= 24'd0;
    else if (sr_out.shift_en) sr_model <= {sr_model[22:0], sr_out.decode_bit};
  end

  int n_vec = 0, n_err = 0;
  int treset_cnt = 0, err_cnt = 0, ovr_cnt = 0, shen_cnt = 0, acc_cnt = 0;
  logic [23:0] acc_data = 24'd0;

  always @(negedge clk) begin
    if (sr_out.treset)   treset_cnt++;
    if (err)             err_cnt++;
    if (ovr)             ovr_cnt++;
    if (sr_out.shift_en) shen_cnt++;
    if (pix_if.pixel_valid && pix_if.pixel_ready) begin
      acc_cnt++;
      acc_data = pix_if.pixel_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bits(input logic [47:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      din = 1'b1; bv = 1'b1; bval = bits[n-1-i];
    end
    @(posedge clk); #1;
    bv = 1'b0; bval = 1'b0; din = 1'b0;
  endtask

  typedef struct {
    logic [47:0] bits;
    int          nbits;
    logic        ready;
    int          err;
    int          ovr;
    int          shen;
    int          acc;
    logic        valid;
    logic [23:0] data;
    logic [15:0] fwd;
    logic [15:0] frames;
  } vec_t;

  vec_t vecs[5];
  int t0, e0, o0, s0, a0;

  initial begin
    vecs[0] = '{48'h2AB,          10, 1'b0, 1, 0, 10, 0, 1'b0, 24'hA5C33C, 16'd0,  16'd1};
    vecs[1] = '{48'h123456,       24, 1'b0, 0, 0, 24, 0, 1'b1, 24'h123456, 16'd0,  16'd2};
    vecs[2] = '{48'hFEDCBA,       24, 1'b0, 0, 1, 24, 0, 1'b1, 24'hFEDCBA, 16'd0,  16'd3};
    vecs[3] = '{48'h0F0F0F999999, 48, 1'b1, 0, 0, 24, 2, 1'b0, 24'h0F0F0F, 16'd24, 16'd4};
    vecs[4] = '{48'hA5C33C,       24, 1'b0, 0, 0, 24, 0, 1'b1, 24'hA5C33C, 16'd0,  16'd5};

    pix_if.pixel_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid",  {31'd0, pix_if.pixel_valid}, 32'd0);
    check("rst_data",   {8'd0, pix_if.pixel_data},   32'd0);
    check("rst_err",    {31'd0, err},                32'd0);
    check("rst_ovr",    {31'd0, ovr},                32'd0);
    check("rst_fcnt",   {16'd0, fcnt},               32'd0);
    check("rst_fbits",  {16'd0, fbits},              32'd0);
    check("rst_treset", {31'd0, sr_out.treset},      32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Full pixel with cycle-exact treset and valid latency.
    drive_bits(48'hA5C33C, 24);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("lat_treset_c%0d", c), {31'd0, sr_out.treset}, {31'd0, (c == 9)});
      check($sformatf("lat_valid_c%0d", c), {31'd0, pix_if.pixel_valid}, {31'd0, (c == 11)});
      if (c == 11) check("lat_data", {8'd0, pix_if.pixel_data}, 32'hA5C33C);
    end

    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1;
      pix_if.pixel_ready = vecs[v].ready;
      t0 = treset_cnt; e0 = err_cnt; o0 = ovr_cnt; s0 = shen_cnt; a0 = acc_cnt;
      drive_bits(vecs[v].bits, vecs[v].nbits);
      repeat (14) @(negedge clk);
      check($sformatf("v%0d_treset", v), treset_cnt - t0, 32'd1);
      check($sformatf("v%0d_err", v),    err_cnt - e0,    vecs[v].err);
      check($sformatf("v%0d_ovr", v),    ovr_cnt - o0,    vecs[v].ovr);
      check($sformatf("v%0d_shen", v),   shen_cnt - s0,   vecs[v].shen);
      check($sformatf("v%0d_acc", v),    acc_cnt - a0,    vecs[v].acc);
      check($sformatf("v%0d_valid", v),  {31'd0, pix_if.pixel_valid}, {31'd0, vecs[v].valid});
      check($sformatf("v%0d_data", v),   {8'd0, pix_if.pixel_data},   {8'd0, vecs[v].data});
      check($sformatf("v%0d_fwd", v),    {16'd0, fbits}, STATS ? {16'd0, vecs[v].fwd} : 32'd0);
      check($sformatf("v%0d_frames", v), {16'd0, fcnt},  STATS ? {16'd0, vecs[v].frames} : 32'd0);
      if (vecs[v].acc > 0) check($sformatf("v%0d_accdata", v), {8'd0, acc_data}, {8'd0, vecs[v].data});
    end

    // Idle glitches: 7 low clocks never reach treset; one pulse per long idle.
    @(posedge clk); #1; din = 1'b1;
    t0 = treset_cnt; e0 = err_cnt;
    @(posedge clk); #1; din = 1'b0;
    repeat (7) @(posedge clk); #1; din = 1'b1;
    @(posedge clk); #1; din = 1'b0;
    repeat (7) @(posedge clk); #1; din = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_no_treset", treset_cnt - t0, 32'd0);
    @(posedge clk); #1; din = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_one_treset", treset_cnt - t0, 32'd1);
    check("idle_no_err",     err_cnt - e0,    32'd0);
    check("idle_pending",    {31'd0, pix_if.pixel_valid}, 32'd1);

    // Reset in FORWARD with a pixel pending.
    @(posedge clk); #1; din = 1'b1;
    drive_bits(48'h3C3C3C3C, 30);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_valid",  {31'd0, pix_if.pixel_valid}, 32'd0);
    check("mrst_data",   {8'd0, pix_if.pixel_data},   32'd0);
    check("mrst_err",    {31'd0, err},                32'd0);
    check("mrst_ovr",    {31'd0, ovr},                32'd0);
    check("mrst_fcnt",   {16'd0, fcnt},               32'd0);
    check("mrst_shen",   {31'd0, sr_out.shift_en},    32'd0);
    @(posedge clk); #1; din = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    s0 = shen_cnt; o0 = ovr_cnt;
    drive_bits(48'h5A5A5A, 24);
    repeat (14) @(negedge clk);
    check("post_shen",   shen_cnt - s0, 32'd24);
    check("post_ovr",    ovr_cnt - o0,  32'd0);
    check("post_valid",  {31'd0, pix_if.pixel_valid}, 32'd1);
    check("post_data",   {8'd0, pix_if.pixel_data},   32'h5A5A5A);
    check("post_frames", {16'd0, fcnt}, STATS ? 32'd1 : 32'd0);

    // Releasing back-pressure: valid holds this cycle, drops the next.
    @(posedge clk); #1; pix_if.pixel_ready = 1'b1;
    @(negedge clk);
    check("rel_valid_hold", {31'd0, pix_if.pixel_valid}, 32'd1);
    @(negedge clk);
    check("rel_valid_drop", {31'd0, pix_if.pixel_valid}, 32'd0);
    check("rel_data_kept",  {8'd0, pix_if.pixel_data},   32'h5A5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
